// File: rtl/instr_dispatch_fsm.sv
// instr_dispatch_fsm: initiator side of the execution-FSM start/done handshake.
// Accepts one instruction at a time, decodes opcode/source/dest, launches the
// matching execution FSM with a one-cycle fsm_start code, holds the operands
// until that FSM reports done, then retires and accepts the next instruction.
// Optional feature macro: DISPATCH_TIMEOUT_EN (WAIT_DONE watchdog).
module instr_dispatch_fsm #(
    parameter logic [15:0] VALID_OPCODE_MASK = 16'h0100,
    parameter int unsigned TIMEOUT_CYCLES    = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [3:0]  fsm_start,
    output logic [5:0]  fsm_source,
    output logic [5:0]  fsm_dest,
    input  logic        fsm_done,
    output logic        busy,
    output logic        retire_pulse,
    output logic        illegal_op,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        LAUNCH,
        WAIT_DONE,
        RETIRE,
        ERROR
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode_q;
    logic       accept;
    logic       is_nop;
    logic       is_legal;
    logic       timeout_hit;

    // An instruction is taken only while idle; anything offered while busy is
    // left for upstream to hold.
    assign accept = (state == IDLE) && instr_valid;

`ifdef DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_count;

    // Watchdog: cleared in LAUNCH, counts WAIT_DONE cycles that see no done.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_count <= '0;
        end else if (state == LAUNCH) begin
            wd_count <= '0;
        end else if ((state == WAIT_DONE) && !fsm_done) begin
            wd_count <= wd_count + 16'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Opcode classification of the latched instruction.
    always_comb begin
        is_nop   = (opcode_q == 4'h0);
        is_legal = VALID_OPCODE_MASK[opcode_q];
    end

    // Next-state logic; a done seen outside WAIT_DONE is stale and ignored.
    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_nop) begin
                    state_next = RETIRE;
                end else if (!is_legal) begin
                    state_next = ERROR;
                end else begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Done has priority over a watchdog expiry in the same cycle.
                if (fsm_done) begin
                    state_next = RETIRE;
`ifdef DISPATCH_TIMEOUT_EN
                end else if (wd_count == TIMEOUT_LIMIT) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
`endif
                end
            end
            RETIRE: begin
                state_next = IDLE;
            end
            ERROR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus registered outputs, each decoded from the state
    // being entered so it is valid for exactly the cycle spent in that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            fsm_start    <= '0;
            retire_pulse <= 1'b0;
            illegal_op   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_next;
            instr_ready  <= (state_next == IDLE);
            busy         <= (state_next != IDLE);
            fsm_start    <= (state_next == LAUNCH) ? opcode_q : '0;
            retire_pulse <= (state_next == RETIRE);
            illegal_op   <= (state_next == ERROR);
            timeout_err  <= timeout_hit;
        end
    end

    // Operand latch: updated only on accept, held through DECODE..RETIRE.
    always_ff @(posedge clock) begin
        if (reset) begin
            opcode_q   <= '0;
            fsm_source <= '0;
            fsm_dest   <= '0;
        end else if (accept) begin
            opcode_q   <= instr[15:12];
            fsm_source <= instr[11:6];
            fsm_dest   <= instr[5:0];
        end
    end

    // Handshake invariants.
    a_start_single : assert property (@(posedge clock) disable iff (reset)
        (fsm_start != '0) |=> (fsm_start == '0));
    a_start_launch : assert property (@(posedge clock) disable iff (reset)
        (fsm_start != '0) |-> (state == LAUNCH));
    a_ready_idle   : assert property (@(posedge clock) disable iff (reset)
        instr_ready == (state == IDLE));
    a_busy_ready   : assert property (@(posedge clock) disable iff (reset)
        busy == !instr_ready);
    a_retire_once  : assert property (@(posedge clock) disable iff (reset)
        retire_pulse |=> !retire_pulse);

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Scoreboard bench for instr_dispatch_fsm: the driver computes, per accepted
// instruction, the edges at which launch/retire/illegal/timeout must appear
// and the busy window, and queues them; the monitor pops on every DUT output.
`timescale 1ns/1ps
module tb_instr_dispatch_fsm;

    localparam logic [15:0] MASK = 16'h0100;
    localparam int unsigned TO   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        fsm_done = 1'b0;
    logic        instr_ready;
    logic [3:0]  fsm_start;
    logic [5:0]  fsm_source;
    logic [5:0]  fsm_dest;
    logic        busy;
    logic        retire_pulse;
    logic        illegal_op;
    logic        timeout_err;

    instr_dispatch_fsm #(
        .VALID_OPCODE_MASK(MASK),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .fsm_start   (fsm_start),
        .fsm_source  (fsm_source),
        .fsm_dest    (fsm_dest),
        .fsm_done    (fsm_done),
        .busy        (busy),
        .retire_pulse(retire_pulse),
        .illegal_op  (illegal_op),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    typedef enum int {EV_LAUNCH, EV_RETIRE, EV_ILLEGAL, EV_TIMEOUT} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         at_edge;
        logic [3:0] code;
    } ev_t;

    ev_t         exp_q[$];
    bit          busy_exp[int];
    logic [11:0] opnd_exp[int];
    bit          done_sched[int];
    logic [11:0] cur_opnd = '0;
    int          cyc = 0;
    int          free_edge = 0;
    int          passed = 0;
    int          total = 0;
    bit          checking = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // fsm_done stimulus from the schedule (value sampled at edge cyc+1).
    always @(posedge clock) begin
        #2;
        fsm_done = done_sched.exists(cyc + 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, req);
    endtask

    task automatic pop_cmp(input ev_kind_t k, input logic [3:0] code);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL spurious_event at edge %0d: got %s expected none", cyc, k.name());
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        check("event_edge", cyc, e.at_edge);
        if (k == EV_LAUNCH) check("fsm_start_code", code, e.code);
    endtask

    // Monitor: outputs set by edge cyc are compared half a cycle later.
    always @(negedge clock) begin
        if (checking) begin
            if (opnd_exp.exists(cyc)) cur_opnd = opnd_exp[cyc];
            check("busy", busy, busy_exp.exists(cyc));
            check("instr_ready", instr_ready, !busy_exp.exists(cyc));
            check("operands", {fsm_source, fsm_dest}, cur_opnd);
            if (fsm_start != '0) pop_cmp(EV_LAUNCH, fsm_start);
            if (retire_pulse) pop_cmp(EV_RETIRE, 4'h0);
            if (illegal_op) pop_cmp(EV_ILLEGAL, 4'h0);
            if (timeout_err) pop_cmp(EV_TIMEOUT, 4'h0);
            while (exp_q.size() > 0 && exp_q[0].at_edge < cyc) begin
                check("event_missing_edge", cyc, exp_q[0].at_edge);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic void push_ev(input ev_kind_t k, input int at, input logic [3:0] code);
        ev_t e;
        e.kind = k;
        e.at_edge = at;
        e.code = code;
        exp_q.push_back(e);
    endfunction

    // Offer w after gap idle cycles; a launched op sees done k cycles after
    // its first WAIT_DONE sample; stale=1 also drives done while it is ignored.
    task automatic issue(input logic [15:0] w, input int gap, input int k, input bit stale);
        int s, t, d, e_end;
        logic [3:0] op;
        if (gap > 0) begin
            instr_valid = 1'b0;
            repeat (gap) step();
        end
        instr_valid = 1'b1;
        instr = w;
        op = w[15:12];
        s = cyc + 1;
        t = (s > free_edge) ? s : free_edge;
        opnd_exp[t] = w[11:0];
        if (op == 4'h0) begin
            push_ev(EV_RETIRE, t + 1, 4'h0);
            e_end = t + 2;
        end else if (!MASK[op]) begin
            push_ev(EV_ILLEGAL, t + 1, 4'h0);
            e_end = t + 2;
        end else begin
            push_ev(EV_LAUNCH, t + 1, op);
            d = t + 3 + k;
`ifdef DISPATCH_TIMEOUT_EN
            if (k >= int'(TO)) begin
                push_ev(EV_TIMEOUT, t + 2 + int'(TO), 4'h0);
                e_end = t + 2 + int'(TO);
            end else begin
                done_sched[d] = 1'b1;
                push_ev(EV_RETIRE, d, 4'h0);
                e_end = d + 1;
            end
`else
            done_sched[d] = 1'b1;
            push_ev(EV_RETIRE, d, 4'h0);
            e_end = d + 1;
`endif
        end
        if (stale) begin
            done_sched[t] = 1'b1;
            done_sched[t + 1] = 1'b1;
            done_sched[t + 2] = 1'b1;
        end
        for (int x = t; x < e_end; x++) busy_exp[x] = 1'b1;
        free_edge = e_end + 1;
        while (cyc < t) step();
    endtask

    initial begin
        logic [15:0] w;
        logic [3:0]  op;
        int          r, s, t;

        repeat (3) step();
        reset = 1'b0;
        free_edge = cyc + 1;
        checking = 1'b1;

        // Directed: MOV immediate, NOP, illegal, recovery, stale done.
        issue(16'h8283, 1, 2, 1'b0);
        issue(16'h0000, 1, 0, 1'b0);
        issue(16'h3ABC, 1, 0, 1'b0);
        issue(16'h8FC1, 1, 0, 1'b0);
        issue(16'h8555, 0, 5, 1'b1);
        // Back-to-back with instr_valid held.
        issue(16'h8041, 0, 1, 1'b0);
        issue(16'h8082, 0, 3, 1'b0);
        issue(16'h80C3, 0, 0, 1'b1);
`ifdef DISPATCH_TIMEOUT_EN
        issue(16'h8111, 1, TO + 2, 1'b0);
        issue(16'h8222, 1, TO - 1, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) op = 4'h8;
            else if (r < 6) op = 4'h0;
            else op = 4'($urandom_range(0, 15));
            w = {op, 12'($urandom)};
            issue(w, $urandom_range(0, 3), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for done: no retire, everything clears.
        w = {4'h8, 12'($urandom)};
        instr_valid = 1'b1;
        instr = w;
        s = cyc + 1;
        t = (s > free_edge) ? s : free_edge;
        opnd_exp[t] = w[11:0];
        push_ev(EV_LAUNCH, t + 1, 4'h8);
        r = t + 5;
        for (int x = t; x < r; x++) busy_exp[x] = 1'b1;
        opnd_exp[r] = 12'h000;
        while (cyc < t) step();
        instr_valid = 1'b0;
        while (cyc < r - 1) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        free_edge = cyc + 1;

        issue(16'h0FFF, 1, 0, 1'b0);
        issue(16'h8A5A, 0, 4, 1'b0);
        instr_valid = 1'b0;

        while (cyc < free_edge + 3) step();
        @(negedge clock);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
